// File: rtl/lc3_common_pkg.sv
// lc3_common_pkg: enable-polarity constants, status struct and enable decode
// shared by the LC-3 datapath bus drivers.
`default_nettype none

package lc3_common_pkg;

  localparam int EN_ACT_HIGH = 0;
  localparam int EN_ACT_LOW  = 1;

  typedef struct packed {
    logic drv_q;
    logic en_err;
  } tri_status_t;

  // Inversion keeps x/z on the enable as x, so the bus resolves to x.
  function automatic logic act_decode(input logic en, input bit en_low);
    return en_low ? ~en : en;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tri_buf_status.sv
// tri_buf_status: drive-monitoring flops (drv_q, saturating drive counter,
// sticky x/z-enable flag). Compiled only when TRI_BUF_STATUS_EN is defined.
`default_nettype none

`ifdef TRI_BUF_STATUS_EN
module tri_buf_status
  import lc3_common_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_act,
  input  logic             i_en,
  output logic             o_drv_q,
  output logic [CNT_W-1:0] o_drv_cnt,
  output logic             o_en_err
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  tri_status_t      r_stat;
  logic [CNT_W-1:0] r_cnt;
  logic             w_en_unk;
  logic             w_act_one;

  // Case-equality checks see x/z in simulation; they fold to 0 in hardware.
  assign w_en_unk  = (i_en !== 1'b0) && (i_en !== 1'b1);
  assign w_act_one = (i_act === 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat <= '0;
      r_cnt  <= '0;
    end else begin
      r_stat.drv_q  <= w_act_one;
      r_stat.en_err <= r_stat.en_err | w_en_unk;
      if (w_act_one && (r_cnt != C_CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_drv_q   = r_stat.drv_q;
  assign o_en_err  = r_stat.en_err;
  assign o_drv_cnt = r_cnt;

endmodule
`endif

`default_nettype wire

// File: rtl/tri_buf.sv
// tri_buf: parameterised tristate driver for the shared LC-3 bus; optional
// drive-monitoring status enabled by macro TRI_BUF_STATUS_EN.
`default_nettype none

module tri_buf
  import lc3_common_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int EN_LOW = EN_ACT_HIGH,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  output tri   [WIDTH-1:0] out,
  output logic             drv_q,
  output logic [CNT_W-1:0] drv_cnt,
  output logic             en_err
);

  logic w_act;

  assign w_act = act_decode(en, EN_LOW != EN_ACT_HIGH);

  // Bus path is purely combinational; rst and clk never touch it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign out[gi] = w_act ? in[gi] : 1'bz;
  end

`ifdef TRI_BUF_STATUS_EN
  tri_buf_status #(
    .CNT_W (CNT_W)
  ) u_status (
    .clk       (clk),
    .rst       (rst),
    .i_act     (w_act),
    .i_en      (en),
    .o_drv_q   (drv_q),
    .o_drv_cnt (drv_cnt),
    .o_en_err  (en_err)
  );
`else
  logic w_unused_clk_rst;

  assign w_unused_clk_rst = &{1'b0, clk, rst};
  assign drv_q            = 1'b0;
  assign drv_cnt          = '0;
  assign en_err           = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tri_buf.sv
// tb_tri_buf: directed scoreboard bench for tri_buf (bus path in both
// polarities and widths, plus status counters when TRI_BUF_STATUS_EN is set).
`default_nettype none

module tb_tri_buf;

`ifdef TRI_BUF_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_h, en_h, in_l, en_l, en_w;
  logic [15:0] in_w;
  tri          out_h, out_l;
  tri   [15:0] out_w;
  logic        q_h, err_h, q_l, err_l, q_w, err_w;
  logic [1:0]  cnt_h;
  logic [15:0] cnt_l, cnt_w;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  // Status model for the CNT_W=2 high-enable instance.
  logic        m_q;
  logic        m_err;
  logic [1:0]  m_cnt;

  tri_buf #(.WIDTH(1), .EN_LOW(0), .CNT_W(2)) u_h (
    .clk(clk), .rst(rst), .in(in_h), .en(en_h), .out(out_h),
    .drv_q(q_h), .drv_cnt(cnt_h), .en_err(err_h));

  tri_buf #(.WIDTH(1), .EN_LOW(1), .CNT_W(16)) u_l (
    .clk(clk), .rst(rst), .in(in_l), .en(en_l), .out(out_l),
    .drv_q(q_l), .drv_cnt(cnt_l), .en_err(err_l));

  tri_buf #(.WIDTH(16), .EN_LOW(0), .CNT_W(16)) u_w (
    .clk(clk), .rst(rst), .in(in_w), .en(en_w), .out(out_w),
    .drv_q(q_w), .drv_cnt(cnt_w), .en_err(err_w));

  function automatic logic [15:0] bus_model(input logic [15:0] d, input logic e,
                                            input bit low, input int w);
    logic [15:0] r;
    logic        act;
    r   = '0;
    act = low ? ~e : e;
    for (int i = 0; i < w; i++) begin
      if ($isunknown(e))  r[i] = 1'bx;
      else if (act === 1'b1) r[i] = d[i];
      else                r[i] = 1'bz;
    end
    return r;
  endfunction

  function automatic logic [15:0] stat_model();
    return STATUS ? {12'b0, m_q, m_err, m_cnt} : 16'h0000;
  endfunction

  task automatic push(input string t, input logic [15:0] e);
    tag_q.push_back(t);
    exp_q.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required <entry>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %b required %b", t, obs, e);
      end
    end
  endtask

  // Rising edge updates the status model from the inputs held at the edge.
  task automatic tick();
    clk = 1'b1;
    if (rst) begin
      m_q = 1'b0; m_err = 1'b0; m_cnt = 2'd0;
    end else begin
      m_q   = (en_h === 1'b1);
      m_err = m_err | $isunknown(en_h);
      if ((en_h === 1'b1) && (m_cnt != 2'd3)) m_cnt = m_cnt + 2'd1;
    end
    #5 clk = 1'b0;
    #5;
  endtask

  logic [1:0] pairs [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  initial begin
    in_h = 1'b0; en_h = 1'b0; in_l = 1'b0; en_l = 1'b1;
    in_w = 16'h0000; en_w = 1'b0;
    m_q = 1'b0; m_err = 1'b0; m_cnt = 2'd0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    push("reset_status", stat_model());
    check({12'b0, q_h, err_h, cnt_h});

    // Truth table with clk idle, both polarities side by side.
    for (int i = 0; i < 4; i++) begin
      {in_h, en_h} = pairs[i];
      {in_l, en_l} = pairs[i];
      push($sformatf("tri_h_%0d", i), bus_model({15'b0, in_h}, en_h, 1'b0, 1));
      push($sformatf("tri_l_%0d", i), bus_model({15'b0, in_l}, en_l, 1'b1, 1));
      #1;
      check({15'b0, out_h});
      check({15'b0, out_l});
    end

    in_w = 16'hA5C3; en_w = 1'b1;
    push("wide_drive", bus_model(in_w, en_w, 1'b0, 16));
    #1 check(out_w);
    en_w = 1'b0;
    push("wide_release", bus_model(in_w, en_w, 1'b0, 16));
    #1 check(out_w);
    en_w = 1'bx;
    push("wide_en_x", bus_model(in_w, en_w, 1'b0, 16));
    #1 check(out_w);
    in_w = 16'h12x4; en_w = 1'b1;
    push("wide_data_x", bus_model(in_w, en_w, 1'b0, 16));
    #1 check(out_w);

    // Counter saturation at CNT_W=2.
    rst = 1'b1; en_h = 1'b0;
    tick();
    rst = 1'b0;
    en_h = 1'b1; in_h = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      push($sformatf("drive_cnt_%0d", k + 1), stat_model());
      check({12'b0, q_h, err_h, cnt_h});
    end

    en_h = 1'bx;
    tick();
    push("en_x_sticky_set", stat_model());
    check({12'b0, q_h, err_h, cnt_h});
    en_h = 1'b0;
    tick();
    push("en_x_sticky_hold", stat_model());
    check({12'b0, q_h, err_h, cnt_h});

    // Reset mid-drive: bus untouched, status clears on the edge.
    en_h = 1'b1; in_h = 1'b1;
    push("pre_rst_out", 16'h0001);
    #1 check({15'b0, out_h});
    rst = 1'b1;
    clk = 1'b1;
    m_q = 1'b0; m_err = 1'b0; m_cnt = 2'd0;
    push("rst_edge_out", 16'h0001);
    push("rst_edge_status", stat_model());
    #1 check({15'b0, out_h});
    check({12'b0, q_h, err_h, cnt_h});
    #4 clk = 1'b0;
    #5 rst = 1'b0;
    push("post_rst_out", 16'h0001);
    #1 check({15'b0, out_h});
    tick();
    push("post_rst_count", stat_model());
    check({12'b0, q_h, err_h, cnt_h});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
